// File: rtl/bus_cycle_ctrl.sv
// Bus machine-cycle controller: sequences T1/T2/TW/T3 bus states for
// opcode fetch, memory/IO read/write and interrupt acknowledge cycles,
// grants HOLD between cycles and flags excessive READY wait states.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no cycle in progress, bus released, strobes inactive
// T1     | address phase: ALE high, A7..A0 on AD bus, status driven
// T2     | strobe asserted, READY sampled at end of state
// TW     | wait state inserted while READY is low
// T3     | strobe still asserted, read data captured on exit
// DONE   | cycle-complete slot when no new request follows T3
// HLDA_S | bus granted to external master while HOLD is high

module bus_cycle_ctrl #(
  parameter int WAIT_MAX = 8
) (
  input  logic        phi1,
  input  logic        reset,
  input  logic        cyc_req,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        ready,
  input  logic        hold,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        ALE,
  output logic        RDn,
  output logic        WRn,
  output logic        INTAn,
  output logic        IOMn,
  output logic        S1,
  output logic        S0,
  output logic        HLDA,
  output logic        busy,
  output logic [7:0]  rdata,
  output logic        cyc_done,
  output logic        wait_err
);

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    DONE,
    HLDA_S
  } state_t;

  localparam logic [2:0] TYPE_OPFETCH = 3'b000;
  localparam logic [2:0] TYPE_MEMRD   = 3'b001;
  localparam logic [2:0] TYPE_MEMWR   = 3'b010;
  localparam logic [2:0] TYPE_IORD    = 3'b011;
  localparam logic [2:0] TYPE_IOWR    = 3'b100;
  localparam logic [2:0] TYPE_INTACK  = 3'b101;

  // Counter only needs to reach WAIT_MAX+1; it saturates there.
  localparam int               CNT_W     = $clog2(WAIT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_MAX);

  state_t            state_q;
  state_t            state_d;

  logic [15:0]       addr_q;
  logic [2:0]        type_q;
  logic [7:0]        wdata_q;
  logic [2:0]        status_q;
  logic [7:0]        rdata_q;
  logic              cyc_done_q;
  logic              wait_err_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic              type_valid;
  logic              can_accept;
  logic              accept;
  logic              rd_cyc;
  logic              wr_cyc;
  logic              ia_cyc;
  logic [2:0]        status_new;

  // IOMn/S1/S0 encoding for each cycle type.
  function automatic logic [2:0] status_of(input logic [2:0] t);
    logic [2:0] s;
    s = 3'b000;
    case (t)
      TYPE_OPFETCH: s = 3'b011;
      TYPE_MEMRD:   s = 3'b010;
      TYPE_MEMWR:   s = 3'b001;
      TYPE_IORD:    s = 3'b110;
      TYPE_IOWR:    s = 3'b101;
      TYPE_INTACK:  s = 3'b111;
      default:      s = 3'b000;
    endcase
    return s;
  endfunction

  assign type_valid = (cyc_type != 3'b110) && (cyc_type != 3'b111);
  assign can_accept = (state_q == IDLE) || (state_q == DONE) || (state_q == T3);
  // HOLD wins over a pending request at every acceptance point.
  assign accept     = cyc_req && type_valid && !hold && can_accept;
  assign status_new = status_of(cyc_type);

  // Strobe selection follows the registered type, not the live input.
  assign rd_cyc = (type_q == TYPE_OPFETCH) || (type_q == TYPE_MEMRD) ||
                  (type_q == TYPE_IORD);
  assign wr_cyc = (type_q == TYPE_MEMWR) || (type_q == TYPE_IOWR);
  assign ia_cyc = (type_q == TYPE_INTACK);

  // State register.
  always_ff @(posedge phi1) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-state bus pin drive.
  always_comb begin
    state_d = state_q;
    ALE     = 1'b0;
    ad_oe   = 1'b0;
    ad_out  = 8'h00;
    RDn     = 1'b1;
    WRn     = 1'b1;
    INTAn   = 1'b1;
    HLDA    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = hold;
        if (hold) begin
          state_d = HLDA_S;
        end else if (accept) begin
          state_d = T1;
        end
      end
      T1: begin
        busy    = 1'b1;
        ALE     = 1'b1;
        ad_oe   = 1'b1;
        ad_out  = addr_q[7:0];
        state_d = T2;
      end
      T2, TW: begin
        busy  = 1'b1;
        RDn   = !rd_cyc;
        WRn   = !wr_cyc;
        INTAn = !ia_cyc;
        if (wr_cyc) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
        state_d = ready ? T3 : TW;
      end
      T3: begin
        busy  = hold;
        RDn   = !rd_cyc;
        WRn   = !wr_cyc;
        INTAn = !ia_cyc;
        if (wr_cyc) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
        if (hold) begin
          state_d = HLDA_S;
        end else if (accept) begin
          state_d = T1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy = hold;
        if (hold) begin
          state_d = HLDA_S;
        end else if (accept) begin
          state_d = T1;
        end else begin
          state_d = IDLE;
        end
      end
      HLDA_S: begin
        busy    = 1'b1;
        HLDA    = 1'b1;
        state_d = hold ? HLDA_S : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance so the cycle is immune to input changes.
  always_ff @(posedge phi1) begin
    if (reset) begin
      addr_q   <= 16'h0000;
      type_q   <= 3'b000;
      wdata_q  <= 8'h00;
      status_q <= 3'b000;
    end else if (accept) begin
      addr_q   <= addr;
      type_q   <= cyc_type;
      wdata_q  <= wdata;
      status_q <= status_new;
    end
  end

  // Completion pulse and read-data capture on the edge leaving T3.
  always_ff @(posedge phi1) begin
    if (reset) begin
      cyc_done_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      cyc_done_q <= (state_q == T3);
      if ((state_q == T3) && (rd_cyc || ia_cyc)) begin
        rdata_q <= ad_in;
      end
    end
  end

  // Count completed wait states; the error flag is sticky until reset.
  always_ff @(posedge phi1) begin
    if (reset) begin
      wait_cnt_q <= '0;
      wait_err_q <= 1'b0;
    end else if (state_q == TW) begin
      if (wait_cnt_q != CNT_SAT) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      if (wait_cnt_q >= CNT_LIMIT) begin
        wait_err_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign a_hi             = addr_q[15:8];
  assign {IOMn, S1, S0}   = status_q;
  assign rdata            = rdata_q;
  assign cyc_done         = cyc_done_q;
  assign wait_err         = wait_err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed bus cycles with a
// per-cycle reference model plus literal expectations at key points.

module tb_bus_cycle_ctrl;

  localparam int WAIT_MAX = 8;

  logic        phi1 = 1'b0;
  logic        reset;
  logic        cyc_req;
  logic [2:0]  cyc_type;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        hold;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ALE;
  logic        RDn;
  logic        WRn;
  logic        INTAn;
  logic        IOMn;
  logic        S1;
  logic        S0;
  logic        HLDA;
  logic        busy;
  logic [7:0]  rdata;
  logic        cyc_done;
  logic        wait_err;

  int total = 0;
  int bad   = 0;
  int wr_low_cnt = 0;

  always #5 phi1 = ~phi1;

  bus_cycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .phi1     (phi1),
    .reset    (reset),
    .cyc_req  (cyc_req),
    .cyc_type (cyc_type),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .hold     (hold),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .a_hi     (a_hi),
    .ALE      (ALE),
    .RDn      (RDn),
    .WRn      (WRn),
    .INTAn    (INTAn),
    .IOMn     (IOMn),
    .S1       (S1),
    .S0       (S0),
    .HLDA     (HLDA),
    .busy     (busy),
    .rdata    (rdata),
    .cyc_done (cyc_done),
    .wait_err (wait_err)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] stat_of(input logic [2:0] t);
    case (t)
      3'd0:    return 3'b011;
      3'd1:    return 3'b010;
      3'd2:    return 3'b001;
      3'd3:    return 3'b110;
      3'd4:    return 3'b101;
      3'd5:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_rd(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd3);
  endfunction

  function automatic logic is_wr(input logic [2:0] t);
    return (t == 3'd2) || (t == 3'd4);
  endfunction

  // Reference model: phase 0 idle, 1 address, 2 strobe, 3 wait,
  // 4 last strobe, 5 done slot, 6 bus granted.
  int          m_ph = 0;
  int          m_waits = 0;
  logic [2:0]  m_type = 3'd0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_wdata = 8'h0;
  logic [7:0]  m_rdata = 8'h0;
  logic        m_done = 1'b0;
  logic        m_werr = 1'b0;
  logic        m_fresh = 1'b1;
  logic        m_valid = 1'b0;

  always @(posedge phi1) begin
    if (reset) begin
      m_ph = 0; m_waits = 0; m_type = 3'd0; m_addr = 16'h0; m_wdata = 8'h0;
      m_rdata = 8'h0; m_done = 1'b0; m_werr = 1'b0; m_fresh = 1'b1; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = (m_ph == 4);
      if (m_ph == 4 && (is_rd(m_type) || m_type == 3'd5)) m_rdata = ad_in;
      case (m_ph)
        0, 4, 5: begin
          if (hold) m_ph = 6;
          else if (cyc_req && cyc_type <= 3'd5) begin
            m_type = cyc_type; m_addr = addr; m_wdata = wdata;
            m_waits = 0; m_fresh = 1'b0; m_ph = 1;
          end else m_ph = (m_ph == 4) ? 5 : 0;
        end
        1: m_ph = 2;
        2, 3: begin
          if (m_ph == 3) begin
            m_waits++;
            if (m_waits > WAIT_MAX) m_werr = 1'b1;
          end
          m_ph = ready ? 4 : 3;
        end
        6: m_ph = hold ? 6 : 0;
        default: m_ph = 0;
      endcase
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge phi1) begin
    logic strobe;
    logic exp_oe;
    if (m_valid) begin
      strobe = (m_ph == 2) || (m_ph == 3) || (m_ph == 4);
      exp_oe = (m_ph == 1) || (strobe && is_wr(m_type));
      chk("ALE", ALE, m_ph == 1);
      chk("ad_oe", ad_oe, exp_oe);
      if (exp_oe) chk("ad_out", ad_out, (m_ph == 1) ? m_addr[7:0] : m_wdata);
      else if (m_fresh) chk("ad_out_rst", ad_out, 0);
      chk("RDn", RDn, !(strobe && is_rd(m_type)));
      chk("WRn", WRn, !(strobe && is_wr(m_type)));
      chk("INTAn", INTAn, !(strobe && m_type == 3'd5));
      chk("HLDA", HLDA, m_ph == 6);
      chk("busy", busy, (m_ph == 1) || (m_ph == 2) || (m_ph == 3) || (m_ph == 6) ||
                        (hold && (m_ph == 0 || m_ph == 4 || m_ph == 5)));
      if ((m_ph >= 1 && m_ph <= 5) || m_fresh) begin
        chk("a_hi", a_hi, m_addr[15:8]);
        chk("status", {IOMn, S1, S0}, m_fresh ? 3'b000 : stat_of(m_type));
      end
      chk("cyc_done", cyc_done, m_done);
      chk("rdata", rdata, m_rdata);
      chk("wait_err", wait_err, m_werr);
    end
  end

  always @(negedge phi1) if (WRn === 1'b0) wr_low_cnt++;

  task automatic tick();
    @(posedge phi1);
    #2;
  endtask

  // Runs one cycle from IDLE/DONE; returns in the slot after T3.
  task automatic run_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d,
                           input int nwait, input logic [7:0] din,
                           output logic [2:0] st1, output logic [7:0] dout2);
    cyc_req = 1'b1; cyc_type = t; addr = a; wdata = d;
    tick();
    cyc_req = 1'b0;
    st1 = {IOMn, S1, S0};
    tick();
    dout2 = ad_out;
    ready = (nwait == 0);
    for (int w = 1; w <= nwait; w++) begin
      tick();
      ready = (w == nwait);
    end
    tick();
    ad_in = din;
    tick();
  endtask

  logic [2:0] st;
  logic [7:0] dout;

  initial begin
    reset = 1'b1; cyc_req = 1'b0; cyc_type = 3'd0; addr = 16'h0; wdata = 8'h0;
    ready = 1'b1; hold = 1'b0; ad_in = 8'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ad_out", ad_out, 8'h00);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_a_hi", a_hi, 8'h00);
    chk("rst_strobes", {ALE, RDn, WRn, INTAn}, 4'b0111);
    chk("rst_status", {IOMn, S1, S0}, 3'b000);
    chk("rst_misc", {HLDA, busy, cyc_done, wait_err}, 4'b0000);
    chk("rst_rdata", rdata, 8'h00);

    // reserved types are ignored
    cyc_req = 1'b1; cyc_type = 3'd6; addr = 16'hFFFF;
    tick(); chk("rsv6_ale", ALE, 0);
    cyc_type = 3'd7;
    tick(); chk("rsv7_ale", ALE, 0);
    tick(); chk("rsv_done", cyc_done, 0);
    cyc_req = 1'b0;

    // opcode fetch
    cyc_req = 1'b1; cyc_type = 3'd0; addr = 16'h1234;
    tick();
    cyc_req = 1'b0;
    chk("of_ale", ALE, 1);
    chk("of_ad_out", ad_out, 8'h34);
    chk("of_a_hi", a_hi, 8'h12);
    chk("of_status", {IOMn, S1, S0}, 3'b011);
    tick(); chk("of_rd_t2", RDn, 0);
    tick(); chk("of_rd_t3", RDn, 0);
    ad_in = 8'h3E;
    tick();
    chk("of_rdata", rdata, 8'h3E);
    chk("of_done", cyc_done, 1);
    tick();

    // memory write with two wait states
    wr_low_cnt = 0;
    ready = 1'b0;
    run_cycle(3'd2, 16'h2000, 8'hA5, 2, 8'h00, st, dout);
    chk("mw_status", st, 3'b001);
    chk("mw_ad_out", dout, 8'hA5);
    chk("mw_wr_low", wr_low_cnt, 4);
    chk("mw_werr", wait_err, 0);
    tick();

    // io write and interrupt acknowledge
    run_cycle(3'd4, 16'h0042, 8'h5A, 0, 8'h00, st, dout);
    chk("iw_status", st, 3'b101);
    chk("iw_ad_out", dout, 8'h5A);
    tick();
    run_cycle(3'd5, 16'h0000, 8'h00, 1, 8'hC7, st, dout);
    chk("ia_status", st, 3'b111);
    chk("ia_rdata", rdata, 8'hC7);
    tick();

    // back-to-back io reads
    cyc_req = 1'b1; cyc_type = 3'd3; addr = 16'h0080;
    tick();
    addr = 16'h0081;
    tick(); tick();
    ad_in = 8'h11;
    tick();
    chk("b2b_ale", ALE, 1);
    chk("b2b_done", cyc_done, 1);
    chk("b2b_rdata", rdata, 8'h11);
    chk("b2b_ad_out", ad_out, 8'h81);
    cyc_req = 1'b0;
    tick(); tick();
    ad_in = 8'h22;
    tick();
    chk("b2b_done2", cyc_done, 1);
    chk("b2b_rdata2", rdata, 8'h22);
    tick();

    // hold raised mid-cycle
    cyc_req = 1'b1; cyc_type = 3'd1; addr = 16'h3456;
    tick();
    cyc_req = 1'b0;
    tick();
    hold = 1'b1;
    tick();
    chk("hd_t3_rd", RDn, 0);
    chk("hd_t3_hlda", HLDA, 0);
    tick();
    chk("hd_hlda", HLDA, 1);
    chk("hd_oe", ad_oe, 0);
    chk("hd_done", cyc_done, 1);
    tick();
    chk("hd_hlda2", HLDA, 1);
    hold = 1'b0;
    tick();
    chk("hd_release", HLDA, 0);
    hold = 1'b1; cyc_req = 1'b1; cyc_type = 3'd1;
    tick();
    chk("hd_prio_hlda", HLDA, 1);
    chk("hd_prio_ale", ALE, 0);
    cyc_req = 1'b0; hold = 1'b0;
    tick();
    chk("hd_prio_rel", HLDA, 0);

    // reset during a wait state
    cyc_req = 1'b1; cyc_type = 3'd1; addr = 16'h4000;
    tick();
    cyc_req = 1'b0; ready = 1'b0;
    tick(); tick();
    chk("rw_in_tw", RDn, 0);
    reset = 1'b1;
    tick();
    chk("rw_rdn", RDn, 1);
    chk("rw_done", cyc_done, 0);
    chk("rw_rdata", rdata, 8'h00);
    chk("rw_busy", busy, 0);
    reset = 1'b0; ready = 1'b1;
    tick();

    // wait-state limit: WAIT_MAX waits is fine, one more flags
    run_cycle(3'd1, 16'h5000, 8'h00, WAIT_MAX, 8'h99, st, dout);
    chk("wm_ok", wait_err, 0);
    chk("wm_rdata", rdata, 8'h99);
    tick();
    run_cycle(3'd1, 16'h6000, 8'h00, WAIT_MAX + 1, 8'h77, st, dout);
    chk("wm_err", wait_err, 1);
    tick(); tick(); tick();
    chk("wm_sticky", wait_err, 1);
    reset = 1'b1;
    tick();
    chk("wm_clear", wait_err, 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
